// File: rtl/ucsbece154b_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// default timing/size parameters and a small alignment helper.
package ucsbece154b_dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_LATENCY_DEFAULT    = 3;
    localparam int DMEM_DEPTH_LOG2_DEFAULT = 10;
    localparam int DMEM_CNT_WIDTH          = 4;

    // A word access is misaligned whenever either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return byte_offset != 2'b00;
    endfunction

endpackage

// File: rtl/ucsbece154b_dmem_responder_array.sv
// Single-port word RAM backing the data-memory responder.
// Writes happen on the rising clock edge; reads are combinational so the
// responder can register the selected word in the same cycle it completes.
// Contents are deliberately never reset.
module ucsbece154b_dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ucsbece154b_dmem_responder.sv
// Memory-stage data responder: accepts one lw/sw at a time, models a fixed
// access latency while requesting a pipeline stall, then performs the RAM
// access and pulses done for one cycle with the load data registered.
module ucsbece154b_dmem_responder
    import ucsbece154b_dmem_responder_pkg::*;
#(
    parameter int LATENCY    = DMEM_LATENCY_DEFAULT,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam logic [DMEM_CNT_WIDTH-1:0] CNT_LOAD = DMEM_CNT_WIDTH'(LATENCY - 1);

    dmem_state_t               state;
    dmem_state_t               state_next;
    logic [DMEM_CNT_WIDTH-1:0] cnt;
    logic [DMEM_CNT_WIDTH-1:0] cnt_next;

    logic                  we_q;
    logic [DEPTH_LOG2-1:0] word_q;
    logic [1:0]            offset_q;
    logic [31:0]           wdata_q;

    logic                  capture;
    logic                  access;
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_word;
    logic [1:0]            acc_offset;
    logic [31:0]           acc_wdata;
    logic                  acc_misaligned;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    // Address bits above the RAM index are intentionally ignored (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[31:DEPTH_LOG2+2];

    // State, latency counter and captured request fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DMEM_IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            word_q   <= '0;
            offset_q <= 2'b00;
            wdata_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                we_q     <= we_i;
                word_q   <= addr_i[DEPTH_LOG2+1:2];
                offset_q <= addr_i[1:0];
                wdata_q  <= wdata_i;
            end
        end
    end

    // Next-state logic; the access fires on the edge that enters DONE, which is
    // the edge where the counter reaches zero (or the accept edge for LATENCY=1).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (req_i) begin
                    capture  = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (LATENCY == 1) begin
                        access     = 1'b1;
                        state_next = DMEM_DONE;
                    end else begin
                        state_next = DMEM_BUSY;
                    end
                end
            end
            DMEM_BUSY: begin
                if (!req_i) begin
                    state_next = DMEM_IDLE;
                    cnt_next   = '0;
                end else if (cnt == DMEM_CNT_WIDTH'(1)) begin
                    access     = 1'b1;
                    cnt_next   = '0;
                    state_next = DMEM_DONE;
                end else begin
                    cnt_next = cnt - DMEM_CNT_WIDTH'(1);
                end
            end
            DMEM_DONE: begin
                state_next = DMEM_IDLE;
            end
            default: begin
                state_next = DMEM_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // On the accept cycle the request fields are not yet captured, so the
    // access operands come straight from the inputs in that case.
    always_comb begin
        acc_we         = capture ? we_i : we_q;
        acc_word       = capture ? addr_i[DEPTH_LOG2+1:2] : word_q;
        acc_offset     = capture ? addr_i[1:0] : offset_q;
        acc_wdata      = capture ? wdata_i : wdata_q;
        acc_misaligned = is_misaligned(acc_offset);
        mem_we         = access && acc_we && !acc_misaligned && reset;
    end

    ucsbece154b_dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (acc_word),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );

    // Registered completion outputs; rdata holds until the next completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_o    <= '0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            done_o     <= access;
            misalign_o <= access && acc_misaligned;
            if (access && acc_misaligned) begin
                rdata_o <= '0;
            end else if (access && !acc_we) begin
                rdata_o <= mem_rdata;
            end
        end
    end

    assign stall_o = req_i && (state != DMEM_DONE);

endmodule

// File: tb/tb_ucsbece154b_dmem_responder.sv
// Directed self-checking bench for ucsbece154b_dmem_responder.
// Two instances share inputs: one with LATENCY=3, one with LATENCY=1.
module tb_ucsbece154b_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata0, rdata1;
    logic        done0, done1;
    logic        stall0, stall1;
    logic        mis0, mis1;

    int checks;
    int fails;

    int          done_cycle;
    int          stall_count;
    logic [31:0] seen_rdata;
    logic        seen_mis;

    ucsbece154b_dmem_responder #(.LATENCY(3), .DEPTH_LOG2(10)) dut0 (
        .clk       (clk),
        .reset     (rst_n),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata0),
        .done_o    (done0),
        .stall_o   (stall0),
        .misalign_o(mis0)
    );

    ucsbece154b_dmem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk       (clk),
        .reset     (rst_n),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata1),
        .done_o    (done1),
        .stall_o   (stall1),
        .misalign_o(mis1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request on the selected instance and record what it does:
    // cycle of done (counted from the accept cycle), stall cycles, data, misalign.
    task automatic run_access(input logic sel, input logic store,
                              input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req = 1'b1; we = store; addr = a; wdata = d;
        done_cycle  = -1;
        stall_count = 0;
        seen_rdata  = 32'hx;
        seen_mis    = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((sel ? stall1 : stall0) === 1'b1) stall_count++;
            if ((sel ? done1 : done0) === 1'b1) begin
                done_cycle = c;
                seen_rdata = sel ? rdata1 : rdata0;
                seen_mis   = sel ? mis1 : mis0;
                break;
            end
        end
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);
        checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done0); end
        checks++; if (rdata0 !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata0); end
        checks++; if (mis0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_misalign: got %b expected 0", mis0); end
        checks++; if (stall0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall_noreq: got %b expected 0", stall0); end
        req = 1'b1; #1;
        checks++; if (stall0 !== 1'b1) begin fails++; $display("[TB] FAIL reset_stall_req: got %b expected 1", stall0); end
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        checks++; if (done_cycle !== 3) begin fails++; $display("[TB] FAIL sw_done_cycle: got %0d expected 3", done_cycle); end
        checks++; if (stall_count !== 3) begin fails++; $display("[TB] FAIL sw_stall_cycles: got %0d expected 3", stall_count); end
        checks++; if (seen_mis !== 1'b0) begin fails++; $display("[TB] FAIL sw_misalign: got %b expected 0", seen_mis); end
        run_access(1'b0, 1'b0, 32'h10, 32'h0);
        checks++; if (done_cycle !== 3) begin fails++; $display("[TB] FAIL lw_done_cycle: got %0d expected 3", done_cycle); end
        checks++; if (seen_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", seen_rdata); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF);
        checks++; if (done_cycle !== 3) begin fails++; $display("[TB] FAIL mis_done_cycle: got %0d expected 3", done_cycle); end
        checks++; if (seen_mis !== 1'b1) begin fails++; $display("[TB] FAIL mis_flag: got %b expected 1", seen_mis); end
        checks++; if (seen_rdata !== 32'h0) begin fails++; $display("[TB] FAIL mis_rdata: got %h expected 00000000", seen_rdata); end
        run_access(1'b0, 1'b0, 32'h10, 32'h0);
        checks++; if (seen_rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL mis_no_write: got %h expected deadbeef", seen_rdata); end
        checks++; if (seen_mis !== 1'b0) begin fails++; $display("[TB] FAIL mis_flag_clear: got %b expected 0", seen_mis); end
    endtask

    task automatic test_wrap();
        run_access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5);
        run_access(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (seen_rdata !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL wrap_rdata: got %h expected a5a5a5a5", seen_rdata); end
    endtask

    task automatic test_abort();
        int done_seen;
        run_access(1'b0, 1'b1, 32'h20, 32'h77);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
        run_access(1'b0, 1'b0, 32'h20, 32'h0);
        checks++; if (seen_rdata !== 32'h77) begin fails++; $display("[TB] FAIL abort_no_write: got %h expected 00000077", seen_rdata); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b0; req = 1'b0;
        #1;
        checks++; if (rdata0 !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_rdata: got %h expected 00000000", rdata0); end
        checks++; if (done0 !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_done: got %b expected 0", done0); end
        checks++; if (rdata1 !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_rdata_l1: got %h expected 00000000", rdata1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin fails++; $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); end
        run_access(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (done_cycle !== 3) begin fails++; $display("[TB] FAIL rstmid_restart_cycle: got %0d expected 3", done_cycle); end
        checks++; if (seen_rdata !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL rstmid_ram_kept: got %h expected a5a5a5a5", seen_rdata); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_done = (c == 3) || (c == 7);
            checks++; if (done0 !== exp_done) begin fails++; $display("[TB] FAIL b2b_done_c%0d: got %b expected %b", c, done0, exp_done); end
            checks++; if (stall0 !== !exp_done) begin fails++; $display("[TB] FAIL b2b_stall_c%0d: got %b expected %b", c, stall0, !exp_done); end
            if (c == 3) begin
                checks++; if (rdata0 !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL b2b_rdata_first: got %h expected deadbeef", rdata0); end
                @(posedge clk); #1;
                addr = 32'h20;
            end
            if (c == 7) begin
                checks++; if (rdata0 !== 32'h77) begin fails++; $display("[TB] FAIL b2b_rdata_second: got %h expected 00000077", rdata0); end
            end
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic test_latency_one();
        run_access(1'b1, 1'b1, 32'h0, 32'h12345678);
        checks++; if (done_cycle !== 1) begin fails++; $display("[TB] FAIL l1_sw_done_cycle: got %0d expected 1", done_cycle); end
        checks++; if (stall_count !== 1) begin fails++; $display("[TB] FAIL l1_sw_stall_cycles: got %0d expected 1", stall_count); end
        run_access(1'b1, 1'b0, 32'h0, 32'h0);
        checks++; if (done_cycle !== 1) begin fails++; $display("[TB] FAIL l1_lw_done_cycle: got %0d expected 1", done_cycle); end
        checks++; if (seen_rdata !== 32'h12345678) begin fails++; $display("[TB] FAIL l1_lw_rdata: got %h expected 12345678", seen_rdata); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_latency_one();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
